// File: rtl/activation_pipe_if.sv
// Stream bundle for one side of the activation pipe: valid/ready handshake,
// a 2-bit mode tag and LANES packed signed lanes.
interface activation_pipe_if #(
    parameter int N     = 16,
    parameter int LANES = 4
);
    logic                 valid;
    logic                 ready;
    logic [1:0]           mode;
    logic [LANES*N-1:0]   data;

    // A beat transfers on a rising edge where valid && ready; the producer holds
    // mode/data stable while valid is high and ready is low.
    modport master (output valid, output mode, output data, input ready);
    modport slave  (input valid, input mode, input data, output ready);
endinterface

// File: rtl/activation_pipe.sv
// Three-stage SIMD activation unit: identity / PWL sigmoid / SiLU / ReLU per beat,
// with a single global stall derived from the output handshake.
module activation_pipe #(
    parameter int N     = 16,
    parameter int R     = 6,
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    activation_pipe_if.slave    in_if,
    activation_pipe_if.master   out_if
);
    localparam logic [N-1:0] ONE     = N'(2 ** R);
    localparam logic [N-1:0] T_SEG3  = N'(5 * 2 ** R);
    localparam logic [N-1:0] T_SEG2  = N'(19 * 2 ** (R - 3));
    localparam logic [N-1:0] C_SEG2  = N'(27 * 2 ** (R - 5));
    localparam logic [N-1:0] C_SEG1  = N'(5 * 2 ** (R - 3));
    localparam logic [N-1:0] C_SEG0  = N'(2 ** (R - 1));
    localparam logic [N-1:0] MAX_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [2*N-1:0] SAT_HI = {{(N+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [2*N-1:0] SAT_LO = {{(N+1){1'b1}}, {(N-1){1'b0}}};

    localparam logic [1:0] MODE_ID   = 2'b00;
    localparam logic [1:0] MODE_SIG  = 2'b01;
    localparam logic [1:0] MODE_SILU = 2'b10;

    // The most negative input has no positive twin, so its magnitude clamps.
    function automatic logic [N-1:0] abs_sat(input logic [N-1:0] x);
        if (x == MIN_NEG)
            return MAX_POS;
        else if (x[N-1])
            return -x;
        else
            return x;
    endfunction

    function automatic logic [1:0] seg_sel(input logic [N-1:0] a);
        if (a >= T_SEG3)
            return 2'd3;
        else if (a >= T_SEG2)
            return 2'd2;
        else if (a >= ONE)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [N-1:0] sigmoid(input logic [N-1:0] x, input logic [N-1:0] a,
                                             input logic [1:0] seg);
        logic [N-1:0] p;
        case (seg)
            2'd3:    p = ONE;
            2'd2:    p = (a >> 5) + C_SEG2;
            2'd1:    p = (a >> 3) + C_SEG1;
            default: p = (a >> 2) + C_SEG0;
        endcase
        return x[N-1] ? ONE - p : p;
    endfunction

    function automatic logic [N-1:0] silu(input logic signed [N-1:0] x,
                                          input logic signed [N-1:0] s);
        logic signed [2*N-1:0] prod;
        logic signed [2*N-1:0] sh;
        prod = (2*N)'(x) * (2*N)'(s);
        sh   = prod >>> R;
        if (sh > SAT_HI)
            return SAT_HI[N-1:0];
        else if (sh < SAT_LO)
            return SAT_LO[N-1:0];
        else
            return sh[N-1:0];
    endfunction

    function automatic logic [N-1:0] mode_mux(input logic [1:0] m, input logic [N-1:0] x,
                                              input logic [N-1:0] s);
        case (m)
            MODE_ID:   return x;
            MODE_SIG:  return s;
            MODE_SILU: return silu(x, s);
            default:   return x[N-1] ? '0 : x;
        endcase
    endfunction

    logic                s1_v, s2_v, s3_v;
    logic [1:0]          s1_mode, s2_mode, s3_mode;
    logic [N-1:0]        s1_x [LANES];
    logic [N-1:0]        s1_a [LANES];
    logic [1:0]          s1_seg [LANES];
    logic [N-1:0]        s2_x [LANES];
    logic [N-1:0]        s2_s [LANES];
    logic [LANES*N-1:0]  s3_data;
    logic                stall;

    // Any stall freezes all three stages together, so bubbles are never squeezed out.
    assign stall        = s3_v && !out_if.ready;
    assign in_if.ready  = !stall;
    assign out_if.valid = s3_v;
    assign out_if.mode  = s3_mode;
    assign out_if.data  = s3_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            s3_v    <= 1'b0;
            s1_mode <= '0;
            s2_mode <= '0;
            s3_mode <= '0;
            s3_data <= '0;
            for (int i = 0; i < LANES; i++) begin
                s1_x[i]   <= '0;
                s1_a[i]   <= '0;
                s1_seg[i] <= '0;
                s2_x[i]   <= '0;
                s2_s[i]   <= '0;
            end
        end else if (!stall) begin
            s1_v    <= in_if.valid;
            s2_v    <= s1_v;
            s3_v    <= s2_v;
            s1_mode <= in_if.mode;
            s2_mode <= s1_mode;
            s3_mode <= s2_mode;
            for (int i = 0; i < LANES; i++) begin
                s1_x[i]            <= in_if.data[i*N +: N];
                s1_a[i]            <= abs_sat(in_if.data[i*N +: N]);
                s1_seg[i]          <= seg_sel(abs_sat(in_if.data[i*N +: N]));
                s2_x[i]            <= s1_x[i];
                s2_s[i]            <= sigmoid(s1_x[i], s1_a[i], s1_seg[i]);
                s3_data[i*N +: N]  <= mode_mux(s2_mode, s2_x[i], s2_s[i]);
            end
        end
    end
endmodule
